// File: rtl/inst_fetch.sv
// inst_fetch: PC/LR owner and two-byte big-endian instruction fetcher.
// Presents one registered 16-bit instruction per retire to the controller.
module inst_fetch #(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        pc_sel,
    input  logic              lr_en,
    input  logic [ADDR_W-1:0] ea,
    input  logic              inst_ready,
    output logic [15:0]       inst,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] lr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata
);

    localparam logic [1:0] FETCH_HI = 2'd0;
    localparam logic [1:0] FETCH_LO = 2'd1;
    localparam logic [1:0] HOLD     = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] lr_q;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] lr_nxt;
    logic [15:0]       inst_q;

    logic st_hi;
    logic st_lo;
    logic st_hold;
    logic hi_ack;
    logic lo_ack;
    logic retire;
    logic sel_lr;
    logic sel_ea;

    assign st_hi   = (state == FETCH_HI);
    assign st_lo   = (state == FETCH_LO);
    assign st_hold = (state == HOLD);

    // mem_ack only counts while a request is outstanding
    assign hi_ack  = st_hi & mem_ack;
    assign lo_ack  = st_lo & mem_ack;
    assign retire  = st_hold & inst_ready;

    assign sel_lr  = (pc_sel == 2'b01);
    assign sel_ea  = (pc_sel == 2'b10);
    assign pc_inc  = pc_q + ADDR_W'(2);

    // Next PC: sequential, return via LR, or jump to ea; always even
    always_comb begin
        pc_nxt = pc_inc;
        unique case (1'b1)
            sel_lr:  pc_nxt = lr_q;
            sel_ea:  pc_nxt = ea;
            default: pc_nxt = pc_inc;
        endcase
        pc_nxt[0] = 1'b0;
    end

    // Link value is the fall-through address of the retiring instruction
    always_comb begin
        lr_nxt = lr_q;
        if (lr_en) begin
            lr_nxt = pc_inc;
        end
    end

    // Fetch sequencing: high byte, low byte, then hold until retired
    always_comb begin
        state_nxt = state;
        unique case (state)
            FETCH_HI: if (mem_ack)    state_nxt = FETCH_LO;
            FETCH_LO: if (mem_ack)    state_nxt = HOLD;
            HOLD:     if (inst_ready) state_nxt = FETCH_HI;
            default:                  state_nxt = FETCH_HI;
        endcase
    end

    // State register; reset abandons any in-flight fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH_HI;
        end else begin
            state <= state_nxt;
        end
    end

    // PC and LR move together on the retire edge (swap uses old values)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
            lr_q <= '0;
        end else if (retire) begin
            pc_q <= pc_nxt;
            lr_q <= lr_nxt;
        end
    end

    // Instruction register filled byte by byte; stale low byte is harmless
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_q <= 16'h0000;
        end else begin
            if (hi_ack) begin
                inst_q[15:8] <= mem_rdata;
            end
            if (lo_ack) begin
                inst_q[7:0] <= mem_rdata;
            end
        end
    end

    // Request decodes from registers only; reset gating kills it at once
    assign mem_req    = rst_n & (st_hi | st_lo);
    assign mem_addr   = st_lo ? {pc_q[ADDR_W-1:1], 1'b1} : pc_q;
    assign inst       = inst_q;
    assign inst_valid = st_hold;
    assign pc         = pc_q;
    assign lr         = lr_q;

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: randomized fetch/retire traffic against a PC/LR model
// with a byte memory responder that injects configurable wait states.
module tb_inst_fetch;

    localparam int AW = 16;
    localparam logic [AW-1:0] RST_PC = 16'h0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    pc_sel = 2'b00;
    logic          lr_en = 1'b0;
    logic [AW-1:0] ea = '0;
    logic          inst_ready = 1'b0;
    logic [15:0]   inst;
    logic          inst_valid;
    logic [AW-1:0] pc;
    logic [AW-1:0] lr;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack = 1'b0;
    logic [7:0]    mem_rdata = 8'h00;

    inst_fetch #(.ADDR_W(AW), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .pc_sel(pc_sel), .lr_en(lr_en),
        .ea(ea), .inst_ready(inst_ready), .inst(inst),
        .inst_valid(inst_valid), .pc(pc), .lr(lr),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0]    mem [0:65535];
    logic [AW-1:0] pc_m = RST_PC;
    logic [AW-1:0] lr_m = '0;
    int            wait_n = 0;
    int            cur_wait = 0;
    int            wcnt = 0;
    bit            phase = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] word_at(input logic [AW-1:0] a);
        logic [AW-1:0] b;
        b = a + 16'd1;
        return {mem[a], mem[b]};
    endfunction

    // Memory: answers after wait_n idle cycles, checks address each cycle
    always @(negedge clk) begin
        if (!rst_n || !mem_req) begin
            mem_ack = 1'b0;
            wcnt = 0;
            if (!rst_n) phase = 1'b0;
        end else begin
            chk("mem_addr", mem_addr, phase ? pc_m + 16'd1 : pc_m);
            if (wcnt < wait_n) begin
                mem_ack = 1'b0;
                wcnt++;
            end else begin
                mem_ack = 1'b1;
                mem_rdata = mem[mem_addr];
                wcnt = 0;
                phase = ~phase;
            end
        end
    end

    task automatic reset_state_checks();
        chk("rst_req", mem_req, 1'b0);
        chk("rst_addr", mem_addr, RST_PC);
        chk("rst_inst", inst, 16'h0000);
        chk("rst_valid", inst_valid, 1'b0);
        chk("rst_pc", pc, RST_PC);
        chk("rst_lr", lr, 16'h0000);
    endtask

    // Entered at the first negedge of a fetch; returns after retire
    task automatic run_instr(input logic [1:0] sel, input logic lre,
                             input logic [AW-1:0] ea_v, input int hold,
                             input int nw);
        int n;
        logic [15:0] w;
        logic [AW-1:0] np;
        n = 0;
        inst_ready = 1'b0;
        while (!inst_valid && n < 200) begin
            n++;
            inst_ready = 1'($urandom_range(0, 1));
            pc_sel = 2'($urandom_range(0, 3));
            @(negedge clk);
        end
        inst_ready = 1'b0;
        chk("latency", n, 2 * (cur_wait + 1));
        w = word_at(pc_m);
        chk("inst", inst, w);
        chk("pc", pc, pc_m);
        chk("lr", lr, lr_m);
        chk("req_hold", mem_req, 1'b0);
        for (int i = 0; i < hold; i++) begin
            pc_sel = 2'($urandom_range(0, 3));
            @(negedge clk);
            chk("hold_valid", inst_valid, 1'b1);
            chk("hold_inst", inst, w);
            chk("hold_pc", pc, pc_m);
        end
        pc_sel = sel;
        lr_en = lre;
        ea = ea_v;
        inst_ready = 1'b1;
        wait_n = nw;
        cur_wait = nw;
        @(posedge clk);
        case (sel)
            2'b01:   np = lr_m;
            2'b10:   np = ea_v;
            default: np = pc_m + 16'd2;
        endcase
        np = np & 16'hFFFE;
        if (lre) lr_m = pc_m + 16'd2;
        pc_m = np;
        #1;
        chk("ret_pc", pc, pc_m);
        chk("ret_lr", lr, lr_m);
        chk("ret_valid", inst_valid, 1'b0);
        chk("ret_req", mem_req, 1'b1);
        chk("ret_addr", mem_addr, pc_m);
        chk("ret_inst", inst, w);
        @(negedge clk);
        inst_ready = 1'b0;
        lr_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h1A;
        mem[1] = 8'h2B;

        repeat (2) @(posedge clk);
        #1;
        reset_state_checks();
        #1 rst_n = 1'b1;
        @(negedge clk);

        run_instr(2'b00, 1'b0, 16'h0000, 0, 0);
        run_instr(2'b10, 1'b0, 16'h0010, 0, 0);
        run_instr(2'b10, 1'b0, 16'h0041, 1, 0);
        run_instr(2'b10, 1'b0, 16'h0010, 0, 0);
        run_instr(2'b10, 1'b1, 16'h0080, 0, 0);
        run_instr(2'b01, 1'b1, 16'h0000, 0, 1);
        run_instr(2'b01, 1'b0, 16'h0000, 0, 0);
        run_instr(2'b10, 1'b0, 16'hFFFE, 0, 3);
        run_instr(2'b11, 1'b0, 16'h0000, 5, 0);

        for (int k = 0; k < 150; k++) begin
            run_instr(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      16'($urandom), $urandom_range(0, 3),
                      (k == 149) ? 5 : $urandom_range(0, 3));
        end

        n = 0;
        while (phase == 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("lo_reached", n < 100, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        pc_m = RST_PC;
        lr_m = '0;
        #1;
        reset_state_checks();
        @(negedge clk);
        wait_n = 1;
        cur_wait = 1;
        @(posedge clk);
        #1;
        reset_state_checks();
        #1 rst_n = 1'b1;
        #1 chk("rel_req", mem_req, 1'b1);
        chk("rel_addr", mem_addr, RST_PC);
        @(negedge clk);
        run_instr(2'b00, 1'b0, 16'h0000, 1, 0);
        run_instr(2'b10, 1'b1, 16'h1235, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit for the 16-bit single-cycle core: owns the program counter and link register, fetches each 16-bit instruction as two bytes from byte-wide instruction memory over a req/ack handshake, and presents it to the controller on `inst`. It is the producer side of the controller's interface. It supplies `inst` and consumes the controller's `pc_sel` and `lr_en` to choose the next PC.

## Interface
Parameters:
- `ADDR_W`, 16, width of PC, LR, `ea` and memory address.
- `RESET_PC`, 0, PC value loaded on reset. Must be even.

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pc_sel`  in  2  next-PC select from controller: 00/11 = PC+2, 01 = LR, 10 = `ea`.
- `lr_en`  in  1  from controller: write PC+2 into LR at instruction retire.
- `ea`  in  ADDR_W  branch/call target.
- `inst_ready`  in  1  core accepts the current instruction this cycle (retire strobe).
- `inst`  out  16  current instruction, registered.
- `inst_valid`  out  1  `inst` is complete and stable.
- `pc`  out  ADDR_W  address of current instruction.
- `lr`  out  ADDR_W  link register.
- `mem_req`  out  1  byte read request.
- `mem_addr`  out  ADDR_W  byte address of request.
- `mem_ack`  in  1  read complete; `mem_rdata` valid in same cycle.
- `mem_rdata`  in  8  read byte.

## Operation
- Byte order is big-endian: the byte at `pc` is `inst[15:8]` and the byte at `pc+1` is `inst[7:0]`.
- FSM states: FETCH_HI, FETCH_LO, HOLD.
  - FETCH_HI: `mem_req`=1, `mem_addr`=`pc`. On `mem_ack`, capture `inst[15:8]` and go to FETCH_LO.
  - FETCH_LO: `mem_req`=1, `mem_addr`=`pc+1`. On `mem_ack`, capture `inst[7:0]` and go to HOLD.
  - HOLD: `mem_req`=0, `inst_valid`=1. On `inst_ready`, retire and go to FETCH_HI.
- `inst_ready` is ignored outside HOLD.
- `mem_ack` is ignored when `mem_req`=0.
- `mem_req` and `mem_addr` decode from the state and PC registers only. They do not depend combinationally on any input, and stay stable until acked.
- Retire, with all updates in one edge:
  - `pc` ← next PC per `pc_sel`. The next PC is aligned to even by forcing bit 0 to 0, and this applies to `ea` and LR as well.
  - If `lr_en`=1, `lr` ← old `pc`+2.
  - If `lr_en`=1 and `pc_sel`=01 in the same retire, `pc` ← old `lr` and `lr` ← old `pc`+2, as a swap using pre-edge values.
- Arithmetic is modulo 2^ADDR_W. `pc+2` from 0xFFFE wraps to 0x0000, and `pc+1` never carries because `pc` is even.
- `inst` keeps its last value after retire until overwritten byte by byte. The high byte updates while the low byte is stale, and `inst_valid`=0 during the whole refetch.
- Reset is asynchronous and may arrive mid-operation:
  - In-flight fetch is abandoned. `mem_req` drops to 0 immediately, with no wait for ack.
  - State ← FETCH_HI, `pc` ← RESET_PC, `lr` ← 0, `inst` ← 16'h0000 (NOP), `inst_valid` ← 0.
  - `mem_addr` shows RESET_PC during reset. `mem_req` is forced 0 while `rst_n`=0.

## Timing
- First cycle after `rst_n` deasserts: `mem_req`=1, `mem_addr`=RESET_PC.
- With zero-wait memory (`mem_ack` in the request cycle), each instruction takes 3 cycles: FETCH_HI, FETCH_LO, HOLD. `inst_valid` rises 2 cycles after entering FETCH_HI.
- Each ack-wait cycle adds 1 cycle of latency. `mem_addr` is held throughout the wait.
- `pc` and `lr` change only on the retire edge. `pc` is valid during HOLD for the controller to use when computing `ea`.
- `inst_valid` falls in the cycle after retire, and the next fetch request is issued in that same cycle.

## Test plan
- Reset, then zero-wait memory with bytes 0x1A at 0x0000 and 0x2B at 0x0001 → `mem_addr` goes 0x0000 then 0x0001, `inst`=0x1A2B with `inst_valid`=1 in cycle 3. Retire with `pc_sel`=00 → next `mem_addr`=0x0002.
- Branch: `pc`=0x0010, `pc_sel`=10, `ea`=0x0041 → next fetch at 0x0040. `lr` unchanged.
- Call/return: `pc`=0x0010, `pc_sel`=10, `lr_en`=1, `ea`=0x0080 → `lr`=0x0012 and `pc`=0x0080. A later retire with `pc_sel`=01 → `pc`=0x0012. A swap case with `pc_sel`=01 and `lr_en`=1 at `pc`=0x0080 → `pc`=0x0012, `lr`=0x0082.
- Wait states: `mem_ack` delayed 3 cycles on each byte → `mem_addr` stable throughout, `inst_valid` asserts in cycle 9. Holding `inst_ready`=0 for 5 cycles → `inst`, `pc` and `inst_valid` hold.
- Wrap: `pc`=0xFFFE, `pc_sel`=11 → next `pc`=0x0000 and `mem_addr`=0x0000.
- Reset mid-FETCH_LO with ack pending → `mem_req`=0 in the same cycle, `inst`=0x0000, `inst_valid`=0. After release, fetch restarts at RESET_PC.
